// File: rtl/alu_operand_stage.sv
// alu_operand_stage: two-stage valid/ready 4-bit ALU, operand latch followed by registered result and Z/C/N/V flags
module alu_operand_stage #(
  parameter int WIDTH = 4,
  parameter int OPW   = 3
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic [WIDTH-1:0] Op_A,
  input  logic [WIDTH-1:0] Op_B,
  input  logic [OPW-1:0]   Alu_Op,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic [WIDTH-1:0] Result,
  output logic             Flag_Z,
  output logic             Flag_C,
  output logic             Flag_N,
  output logic             Flag_V
);
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [OPW-1:0]   op_q, op_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             z_q, z_d, c_q, c_d, n_q, n_d, v_q, v_d;
  logic             s2_free, s1_adv, acc;
  logic [WIDTH-1:0] bx, r;
  logic [WIDTH:0]   sum;
  logic             c, v;
  always_comb begin
    bx  = op_q[0] ? ~b_q : b_q;
    sum = {1'b0, a_q} + {1'b0, bx} + {{WIDTH{1'b0}}, op_q[0]};
    r   = sum[WIDTH-1:0];
    c   = sum[WIDTH];
    v   = (a_q[WIDTH-1] == bx[WIDTH-1]) && (r[WIDTH-1] != a_q[WIDTH-1]);
    // add and sub share the adder; everything else clears V and redefines C
    if (op_q[OPW-1:1] != 2'b00) begin
      c = 1'b0;
      v = 1'b0;
      case (op_q)
        3'b010:  r = a_q & b_q;
        3'b011:  r = a_q | b_q;
        3'b100:  r = a_q ^ b_q;
        3'b101:  r = ~a_q;
        3'b110:  begin r = {a_q[WIDTH-2:0], 1'b0}; c = a_q[WIDTH-1]; end
        default: begin r = {1'b0, a_q[WIDTH-1:1]}; c = a_q[0]; end
      endcase
    end
  end
  always_comb begin
    s2_free     = !out_valid_q || Out_Ready;
    s1_adv      = s1_valid_q && s2_free;
    In_Ready    = !s1_valid_q || s2_free;
    acc         = In_Valid && In_Ready;
    s1_valid_d  = acc || (s1_valid_q && !s1_adv);
    a_d         = acc ? Op_A : a_q;
    b_d         = acc ? Op_B : b_q;
    op_d        = acc ? Alu_Op : op_q;
    out_valid_d = s1_adv || (out_valid_q && !Out_Ready);
    res_d       = s1_adv ? r : res_q;
    z_d         = s1_adv ? (r == '0) : z_q;
    c_d         = s1_adv ? c : c_q;
    n_d         = s1_adv ? r[WIDTH-1] : n_q;
    v_d         = s1_adv ? v : v_q;
  end
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      s1_valid_q  <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      z_q         <= 1'b0;
      c_q         <= 1'b0;
      n_q         <= 1'b0;
      v_q         <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
      z_q         <= z_d;
      c_q         <= c_d;
      n_q         <= n_d;
      v_q         <= v_d;
    end
  end
  assign Out_Valid = out_valid_q;
  assign Result    = res_q;
  assign Flag_Z    = z_q;
  assign Flag_C    = c_q;
  assign Flag_N    = n_q;
  assign Flag_V    = v_q;
endmodule

// File: tb/tb_alu_operand_stage.sv
// tb_alu_operand_stage: directed and random checks of the ALU stage against an arithmetic queue model
module tb_alu_operand_stage;
  logic       Clk = 1'b0, Reset_n = 1'b0, In_Valid = 1'b0, Out_Ready = 1'b0;
  logic [3:0] Op_A = '0, Op_B = '0;
  logic [2:0] Alu_Op = '0;
  logic       In_Ready, Out_Valid, Flag_Z, Flag_C, Flag_N, Flag_V;
  logic [3:0] Result;
  int checks = 0, errors = 0, cyc = 0;
  typedef struct {logic [3:0] r; logic z, c, n, v; int t;} item_t;
  item_t q[$];
  alu_operand_stage #(.WIDTH(4), .OPW(3)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .In_Valid(In_Valid), .In_Ready(In_Ready),
    .Op_A(Op_A), .Op_B(Op_B), .Alu_Op(Alu_Op), .Out_Valid(Out_Valid),
    .Out_Ready(Out_Ready), .Result(Result), .Flag_Z(Flag_Z), .Flag_C(Flag_C),
    .Flag_N(Flag_N), .Flag_V(Flag_V)
  );
  always #5 Clk = ~Clk;
  function automatic item_t ref_alu(int a, int b, int op);
    item_t it;
    int r, sa, sb, c, v;
    sa = a >= 8 ? a - 16 : a;
    sb = b >= 8 ? b - 16 : b;
    c = 0;
    v = 0;
    case (op)
      0: begin r = a + b; c = r > 15; v = (sa + sb > 7) || (sa + sb < -8); end
      1: begin r = a + 16 - b; c = a >= b; v = (sa - sb > 7) || (sa - sb < -8); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = 15 - a;
      6: begin r = a * 2; c = a >= 8; end
      default: begin r = a / 2; c = a % 2; end
    endcase
    r = r % 16;
    it.r = r[3:0];
    it.z = r == 0;
    it.c = c != 0;
    it.n = r >= 8;
    it.v = v != 0;
    it.t = 0;
    return it;
  endfunction
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step(input bit iv, input int a, input int b, input int op, input bit ordy, output bit accepted);
    bit exp_ready, exp_ov;
    item_t it;
    @(negedge Clk);
    In_Valid = iv; Op_A = a[3:0]; Op_B = b[3:0]; Alu_Op = op[2:0]; Out_Ready = ordy;
    #1;
    exp_ready = !(q.size() == 2 && !ordy);
    exp_ov = q.size() > 0 && q[0].t <= cyc;
    chk("in_ready", {7'b0, In_Ready}, {7'b0, exp_ready});
    chk("out_valid", {7'b0, Out_Valid}, {7'b0, exp_ov});
    if (exp_ov) begin
      chk("result", {4'b0, Result}, {4'b0, q[0].r});
      chk("flags_zcnv", {4'b0, Flag_Z, Flag_C, Flag_N, Flag_V}, {4'b0, q[0].z, q[0].c, q[0].n, q[0].v});
    end
    @(posedge Clk);
    if (exp_ov && ordy) void'(q.pop_front());
    accepted = iv && exp_ready;
    if (accepted) begin
      it = ref_alu(a, b, op);
      it.t = cyc + 2;
      q.push_back(it);
    end
    cyc++;
  endtask
  task automatic do_reset();
    @(negedge Clk);
    Reset_n = 1'b0; In_Valid = 1'b0;
    @(posedge Clk);
    q.delete();
    cyc++;
    @(negedge Clk);
    Reset_n = 1'b1;
    #1;
    chk("rst_out_valid", {7'b0, Out_Valid}, 8'h0);
    chk("rst_result", {4'b0, Result}, 8'h0);
    chk("rst_flags", {4'b0, Flag_Z, Flag_C, Flag_N, Flag_V}, 8'h0);
    chk("rst_in_ready", {7'b0, In_Ready}, 8'h1);
  endtask
  initial begin
    bit acc, pend;
    int a, b, op, iv, ordy;
    repeat (2) @(posedge Clk);
    do_reset();
    step(1, 4'b0111, 4'b1001, 0, 1, acc);
    step(0, 0, 0, 0, 1, acc);
    #1;
    chk("add_wrap_result", {4'b0, Result}, 8'h0);
    chk("add_wrap_flags", {4'b0, Flag_Z, Flag_C, Flag_N, Flag_V}, 8'b1100);
    step(1, 4'b0111, 4'b0001, 0, 1, acc);
    step(1, 4'b0011, 4'b0101, 1, 1, acc);
    step(0, 0, 0, 0, 1, acc);
    step(0, 0, 0, 0, 1, acc);
    step(1, 4'b1001, 0, 6, 1, acc);
    step(1, 4'b1001, 0, 7, 1, acc);
    step(0, 0, 0, 0, 1, acc);
    step(0, 0, 0, 0, 1, acc);
    step(0, 0, 0, 0, 1, acc);
    step(1, 4'b1100, 4'b1010, 2, 0, acc);
    step(1, 4'b1100, 4'b1010, 3, 0, acc);
    step(1, 4'b1100, 4'b1010, 4, 0, acc);
    chk("bp_not_accepted", {7'b0, acc}, 8'h0);
    step(1, 4'b1100, 4'b1010, 4, 0, acc);
    #1;
    chk("bp_hold_result", {4'b0, Result}, 8'b1000);
    step(1, 4'b1100, 4'b1010, 4, 1, acc);
    chk("bp_accept_on_rise", {7'b0, acc}, 8'h1);
    repeat (4) step(0, 0, 0, 0, 1, acc);
    step(1, 4'b0001, 4'b0010, 0, 0, acc);
    step(1, 4'b0011, 4'b0100, 1, 0, acc);
    step(0, 0, 0, 0, 0, acc);
    do_reset();
    repeat (3) step(0, 0, 0, 0, 1, acc);
    step(1, 4'b1000, 4'b0001, 1, 1, acc);
    step(1, 4'b0000, 4'b0000, 5, 1, acc);
    repeat (3) step(0, 0, 0, 0, 1, acc);
    pend = 0;
    iv = 0; a = 0; b = 0; op = 0;
    for (int i = 0; i < 400; i++) begin
      if (!pend) begin
        iv = $urandom_range(0, 3) != 0;
        a = $urandom_range(0, 15);
        b = $urandom_range(0, 15);
        op = $urandom_range(0, 7);
      end
      ordy = $urandom_range(0, 2) != 0;
      step(iv[0], a, b, op, ordy[0], acc);
      pend = iv[0] && !acc;
    end
    repeat (4) step(0, 0, 0, 0, 1, acc);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
